// File: rtl/scr1_tapc_sync_pkg.sv
// Shared constants and event encoding for the TAPC -> SysCLK synchronizer.
package scr1_tapc_sync_pkg;

  // Shallowest synchronizer that still gives metastability settling time.
  localparam int SCR1_TAPC_SYNC_MIN_STAGES = 2;

  // TCK edge events seen in one clk cycle: bit 0 = rise, bit 1 = fall.
  typedef enum logic [1:0] {
    EV_NONE = 2'b00,
    EV_RISE = 2'b01,
    EV_FALL = 2'b10,
    EV_BOTH = 2'b11
  } tapc_sync_ev_e;

endpackage

// File: rtl/scr1_sync_toggle_edge.sv
// Toggle-marker synchronizer: brings an async toggle into clk and emits a
// one-cycle pulse for every flip once it has passed STAGES settling flops.
module scr1_sync_toggle_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tgl_i,
  output logic edge_o
);

  logic [STAGES:0] pipe_q;
  logic [STAGES:0] pipe_d;

  // Shift the raw toggle in at bit 0; older samples move toward the MSB.
  always_comb begin
    pipe_d = {pipe_q[STAGES-1:0], tgl_i};
  end

  // Pipe register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  // A flip shows as a difference between the last settled stage and the one before it.
  assign edge_o = pipe_q[STAGES] ^ pipe_q[STAGES-1];

endmodule

// File: rtl/scr1_tapc_sync_mc.sv
// Multi-channel TAPC -> SysCLK synchronizer. Turns TCK-domain toggle markers
// into one-clk capture/shift/update strobes for the selected debug chain,
// counts shifted bits, returns registered TDO and flags TCK overrun and
// illegal chain selects.
//
// Handshake: there is no back-pressure. Each strobe output is a valid pulse
// lasting exactly one clk; tdi_o is valid only in cycles with a shift strobe.
module scr1_tapc_sync_mc
  import scr1_tapc_sync_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int ID_W        = 7,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter bit UPD_ON_FALL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tck_divpos_i,
  input  logic              tck_divneg_i,
  input  logic [N_CH-1:0]   ch_sel_i,
  input  logic [ID_W-1:0]   ch_id_i,
  input  logic              capture_i,
  input  logic              shift_i,
  input  logic              update_i,
  input  logic              tdi_i,
  input  logic [N_CH-1:0]   tdo_i,
  output logic [N_CH-1:0]   ch_sel_o,
  output logic [ID_W-1:0]   ch_id_o,
  output logic [N_CH-1:0]   capture_o,
  output logic [N_CH-1:0]   shift_o,
  output logic [N_CH-1:0]   update_o,
  output logic              tdi_o,
  output logic [CNT_W-1:0]  shift_cnt_o,
  output logic              tdo_o,
  output logic              overrun_o,
  output logic              sel_err_o,
  input  logic              err_clr_i
);

  localparam int S  = (SYNC_STAGES < SCR1_TAPC_SYNC_MIN_STAGES) ?
                      SCR1_TAPC_SYNC_MIN_STAGES : SYNC_STAGES;
  // Pipes refill from zero after reset; a toggle input already at 1 looks like
  // a flip until it has drained through S+1 flops, so events stay masked that long.
  localparam int MW = $clog2(S + 2);
  localparam logic [MW-1:0]    MASK_DONE = MW'(S + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic          rise_raw, fall_raw;
  logic          ev_en, rise_ev, fall_ev, upd_ev, sel_ok;
  tapc_sync_ev_e ev;
  logic [N_CH-1:0] sel_new;
  logic [3:0]      dsync;

  logic [MW-1:0]          mask_q, mask_d;
  logic [S-1:0][3:0]      dpipe_q, dpipe_d;
  logic [N_CH-1:0]        ch_sel_q, ch_sel_d, cap_q, cap_d, shf_q, shf_d, upd_q, upd_d;
  logic [ID_W-1:0]        ch_id_q, ch_id_d;
  logic                   tdi_q, tdi_d, tdo_q, tdo_d, ovr_q, ovr_d, serr_q, serr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  scr1_sync_toggle_edge #(.STAGES(S)) u_pos (
    .clk(clk), .rst(rst), .tgl_i(tck_divpos_i), .edge_o(rise_raw)
  );
  scr1_sync_toggle_edge #(.STAGES(S)) u_neg (
    .clk(clk), .rst(rst), .tgl_i(tck_divneg_i), .edge_o(fall_raw)
  );

  // Event decode, post-reset mask and select legality check.
  always_comb begin
    ev_en   = (mask_q == MASK_DONE);
    mask_d  = ev_en ? mask_q : mask_q + 1'b1;
    ev      = tapc_sync_ev_e'({fall_raw & ev_en, rise_raw & ev_en});
    rise_ev = (ev == EV_RISE) || (ev == EV_BOTH);
    fall_ev = (ev == EV_FALL) || (ev == EV_BOTH);
    upd_ev  = UPD_ON_FALL ? fall_ev : rise_ev;
    sel_ok  = ((ch_sel_i & (ch_sel_i - 1'b1)) == '0);
    sel_new = sel_ok ? ch_sel_i : '0;
    // Data enters at the same depth as the markers, so a value set up before
    // its marker flip is the one seen when the event fires.
    dpipe_d = {dpipe_q[S-2:0], capture_i, shift_i, update_i, tdi_i};
    dsync   = dpipe_q[S-1];
  end

  // Next-state for strobes, selected-chain state, TDO, counter and error flags.
  always_comb begin
    ch_sel_d = ch_sel_q;
    ch_id_d  = ch_id_q;
    cap_d    = '0;
    shf_d    = '0;
    upd_d    = '0;
    tdi_d    = tdi_q;
    tdo_d    = tdo_q;
    ovr_d    = err_clr_i ? 1'b0 : ovr_q;
    serr_d   = err_clr_i ? 1'b0 : serr_q;
    if (rise_ev) begin
      ch_sel_d = sel_new;
      ch_id_d  = ch_id_i;
      cap_d    = dsync[3] ? sel_new : '0;
      shf_d    = dsync[2] ? sel_new : '0;
      tdi_d    = dsync[0];
      tdo_d    = |(tdo_i & ch_sel_q);
      if (!sel_ok) serr_d = 1'b1;
    end
    if (upd_ev && dsync[1]) upd_d = UPD_ON_FALL ? ch_sel_q : sel_new;
    if (ev == EV_BOTH) ovr_d = 1'b1;
    // Capture wins over a shift strobe in the same cycle.
    cnt_d = cnt_q;
    if (|cap_q)                          cnt_d = '0;
    else if (|shf_q && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  // All state registers; reset dominates every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q   <= '0;
      dpipe_q  <= '0;
      ch_sel_q <= '0;
      ch_id_q  <= '0;
      cap_q    <= '0;
      shf_q    <= '0;
      upd_q    <= '0;
      tdi_q    <= 1'b0;
      tdo_q    <= 1'b0;
      ovr_q    <= 1'b0;
      serr_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mask_q   <= mask_d;
      dpipe_q  <= dpipe_d;
      ch_sel_q <= ch_sel_d;
      ch_id_q  <= ch_id_d;
      cap_q    <= cap_d;
      shf_q    <= shf_d;
      upd_q    <= upd_d;
      tdi_q    <= tdi_d;
      tdo_q    <= tdo_d;
      ovr_q    <= ovr_d;
      serr_q   <= serr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ch_sel_o    = ch_sel_q;
  assign ch_id_o     = ch_id_q;
  assign capture_o   = cap_q;
  assign shift_o     = shf_q;
  assign update_o    = upd_q;
  assign tdi_o       = tdi_q;
  assign shift_cnt_o = cnt_q;
  assign tdo_o       = tdo_q;
  assign overrun_o   = ovr_q;
  assign sel_err_o   = serr_q;

endmodule

// File: tb/tb_scr1_tapc_sync_mc.sv
// Bench for scr1_tapc_sync_mc: a default instance (8-bit counter, update on
// TCK fall) and a second one (3-bit counter, update on TCK rise) share inputs.
module tb_scr1_tapc_sync_mc;
  localparam int N_CH = 2;
  localparam int ID_W = 7;
  localparam int S    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tck_divpos_i = 1'b0, tck_divneg_i = 1'b0;
  logic [N_CH-1:0] ch_sel_i = '0, tdo_i = '0;
  logic [ID_W-1:0] ch_id_i = '0;
  logic capture_i = 1'b0, shift_i = 1'b0, update_i = 1'b0, tdi_i = 1'b0, err_clr_i = 1'b0;

  logic [N_CH-1:0] a_sel, a_cap, a_shf, a_upd, b_sel, b_cap, b_shf, b_upd;
  logic [ID_W-1:0] a_id, b_id;
  logic [7:0] a_cnt;
  logic [2:0] b_cnt;
  logic a_tdi, a_tdo, a_ovr, a_serr, b_tdi, b_tdo, b_ovr, b_serr;

  scr1_tapc_sync_mc dut_a (
    .clk(clk), .rst(rst), .tck_divpos_i(tck_divpos_i), .tck_divneg_i(tck_divneg_i),
    .ch_sel_i(ch_sel_i), .ch_id_i(ch_id_i), .capture_i(capture_i), .shift_i(shift_i),
    .update_i(update_i), .tdi_i(tdi_i), .tdo_i(tdo_i), .ch_sel_o(a_sel), .ch_id_o(a_id),
    .capture_o(a_cap), .shift_o(a_shf), .update_o(a_upd), .tdi_o(a_tdi),
    .shift_cnt_o(a_cnt), .tdo_o(a_tdo), .overrun_o(a_ovr), .sel_err_o(a_serr),
    .err_clr_i(err_clr_i)
  );

  scr1_tapc_sync_mc #(.CNT_W(3), .UPD_ON_FALL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .tck_divpos_i(tck_divpos_i), .tck_divneg_i(tck_divneg_i),
    .ch_sel_i(ch_sel_i), .ch_id_i(ch_id_i), .capture_i(capture_i), .shift_i(shift_i),
    .update_i(update_i), .tdi_i(tdi_i), .tdo_i(tdo_i), .ch_sel_o(b_sel), .ch_id_o(b_id),
    .capture_o(b_cap), .shift_o(b_shf), .update_o(b_upd), .tdi_o(b_tdi),
    .shift_cnt_o(b_cnt), .tdo_o(b_tdo), .overrun_o(b_ovr), .sel_err_o(b_serr),
    .err_clr_i(err_clr_i)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- passive monitor ----------------
  int a_cap_n[N_CH] = '{default: 0};
  int a_shf_n[N_CH] = '{default: 0};
  int a_upd_n[N_CH] = '{default: 0};
  int b_upd_n[N_CH] = '{default: 0};
  int dbl_n = 0;
  int tdi_n = 0;
  logic tdi_hist[4096];
  int unsigned a_upd_cyc = 0, b_upd_cyc = 0;
  logic [N_CH-1:0] pa_cap = '0, pa_shf = '0, pa_upd = '0, pb_upd = '0;

  always @(negedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      a_cap_n[i] += int'(a_cap[i]);
      a_shf_n[i] += int'(a_shf[i]);
      a_upd_n[i] += int'(a_upd[i]);
      b_upd_n[i] += int'(b_upd[i]);
    end
    if (((a_cap & pa_cap) | (a_shf & pa_shf) | (a_upd & pa_upd) | (b_upd & pb_upd)) != '0)
      dbl_n++;
    if (a_upd != '0) a_upd_cyc = cyc;
    if (b_upd != '0) b_upd_cyc = cyc;
    if (a_shf != '0) begin
      if (tdi_n < 4096) tdi_hist[tdi_n] = a_tdi;
      tdi_n++;
    end
    pa_cap = a_cap; pa_shf = a_shf; pa_upd = a_upd; pb_upd = b_upd;
  end

  // Snapshot of monitor counters so each test checks only its own activity.
  int s_cap[N_CH], s_shf[N_CH], s_upd[N_CH], s_bupd[N_CH];
  int s_dbl, s_tdi;
  int unsigned rise_c, fall_c;
  logic [0:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic snap();
    for (int i = 0; i < N_CH; i++) begin
      s_cap[i] = a_cap_n[i]; s_shf[i] = a_shf_n[i];
      s_upd[i] = a_upd_n[i]; s_bupd[i] = b_upd_n[i];
    end
    s_dbl = dbl_n;
    s_tdi = tdi_n;
    exp_q.delete();
  endtask

  // One TCK period of 8 clk: data set up 2 clk before the rise marker,
  // held until 2 clk after the fall marker.
  task automatic tck_cycle(input logic cap, input logic shf, input logic upd, input logic tdi);
    capture_i = cap; shift_i = shf; update_i = upd; tdi_i = tdi;
    repeat (2) @(negedge clk);
    tck_divpos_i = ~tck_divpos_i; rise_c = cyc;
    repeat (4) @(negedge clk);
    tck_divneg_i = ~tck_divneg_i; fall_c = cyc;
    repeat (2) @(negedge clk);
  endtask

  task automatic idle(input int n);
    capture_i = 1'b0; shift_i = 1'b0; update_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int d;
    rst = 1'b1; tck_divpos_i = 1'b1; tck_divneg_i = 1'b1; ch_sel_i = '1; ch_id_i = '1;
    capture_i = 1'b1; shift_i = 1'b1; update_i = 1'b1; tdi_i = 1'b1; tdo_i = '1; err_clr_i = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({a_sel, a_id, a_cap, a_shf, a_upd, a_tdi, a_cnt, a_tdo, a_ovr, a_serr} !== '0) begin
      n_err++; $display("FAIL reset_a got=%h exp=0", {a_sel, a_id, a_cap, a_shf, a_upd, a_tdi, a_cnt, a_tdo, a_ovr, a_serr});
    end
    n_vec++;
    if ({b_sel, b_id, b_cap, b_shf, b_upd, b_tdi, b_cnt, b_tdo, b_ovr, b_serr} !== '0) begin
      n_err++; $display("FAIL reset_b got=%h exp=0", {b_sel, b_id, b_cap, b_shf, b_upd, b_tdi, b_cnt, b_tdo, b_ovr, b_serr});
    end
    rst = 1'b0; err_clr_i = 1'b0;
    snap();
    repeat (8) @(negedge clk);
    d = 0;
    for (int i = 0; i < N_CH; i++)
      d += (a_cap_n[i] - s_cap[i]) + (a_shf_n[i] - s_shf[i]) + (a_upd_n[i] - s_upd[i]) + (b_upd_n[i] - s_bupd[i]);
    n_vec++;
    if (d !== 0) begin n_err++; $display("FAIL post_reset_strobes got=%0d exp=0", d); end
    n_vec++;
    if ({a_serr, b_serr, a_ovr, a_sel} !== '0) begin
      n_err++; $display("FAIL post_reset_flags got=%b exp=0", {a_serr, b_serr, a_ovr, a_sel});
    end
    ch_sel_i = 2'b01; ch_id_i = '0; tdo_i = '0; tdi_i = 1'b0;
    idle(2);
  endtask

  task automatic test_capture_shift();
    logic [ID_W-1:0] id;
    logic b;
    id = ID_W'($urandom_range(0, 127));
    ch_id_i = id; ch_sel_i = 2'b01;
    snap();
    tck_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      b = 1'($urandom_range(0, 1));
      exp_q.push_back(b);
      tck_cycle(1'b0, 1'b1, 1'b0, b);
    end
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    n_vec++;
    if (a_cap_n[0] - s_cap[0] !== 1 || a_cap_n[1] - s_cap[1] !== 0) begin
      n_err++; $display("FAIL cs_capture got=%0d/%0d exp=1/0", a_cap_n[0] - s_cap[0], a_cap_n[1] - s_cap[1]);
    end
    n_vec++;
    if (a_shf_n[0] - s_shf[0] !== 8 || a_shf_n[1] - s_shf[1] !== 0) begin
      n_err++; $display("FAIL cs_shift got=%0d/%0d exp=8/0", a_shf_n[0] - s_shf[0], a_shf_n[1] - s_shf[1]);
    end
    n_vec++;
    if (a_cnt !== 8'd8) begin n_err++; $display("FAIL cs_cnt_a got=%0d exp=8", a_cnt); end
    n_vec++;
    if (b_cnt !== 3'd7) begin n_err++; $display("FAIL cs_cnt_b got=%0d exp=7", b_cnt); end
    n_vec++;
    if (a_id !== id || a_sel !== 2'b01) begin
      n_err++; $display("FAIL cs_id_sel got=%h/%b exp=%h/01", a_id, a_sel, id);
    end
    n_vec++;
    if (tdi_n - s_tdi !== exp_q.size()) begin
      n_err++; $display("FAIL cs_tdi_n got=%0d exp=%0d", tdi_n - s_tdi, exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      n_vec++;
      if (tdi_hist[s_tdi + k] !== exp_q[k][0]) begin
        n_err++; $display("FAIL cs_tdi[%0d] got=%b exp=%b", k, tdi_hist[s_tdi + k], exp_q[k][0]);
      end
    end
    n_vec++;
    if (dbl_n - s_dbl !== 0 || a_upd_n[0] - s_upd[0] !== 0) begin
      n_err++; $display("FAIL cs_width_upd got=%0d/%0d exp=0/0", dbl_n - s_dbl, a_upd_n[0] - s_upd[0]);
    end
  endtask

  task automatic test_saturate();
    tck_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) tck_cycle(1'b0, 1'b1, 1'b0, 1'b1);
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    n_vec++;
    if (a_cnt !== 8'd12) begin n_err++; $display("FAIL sat_cnt_a got=%0d exp=12", a_cnt); end
    n_vec++;
    if (b_cnt !== 3'd7) begin n_err++; $display("FAIL sat_cnt_b got=%0d exp=7", b_cnt); end
    tck_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    n_vec++;
    if (a_cnt !== 8'd0 || b_cnt !== 3'd0) begin
      n_err++; $display("FAIL sat_clear got=%0d/%0d exp=0/0", a_cnt, b_cnt);
    end
  endtask

  task automatic test_update();
    int unsigned rc, fc;
    int la, lb;
    ch_sel_i = 2'b01;
    tck_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tck_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    snap();
    tck_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    rc = rise_c; fc = fall_c;
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    n_vec++;
    if (a_upd_n[0] - s_upd[0] !== 1 || a_upd_n[1] - s_upd[1] !== 0) begin
      n_err++; $display("FAIL upd_cnt_a got=%0d/%0d exp=1/0", a_upd_n[0] - s_upd[0], a_upd_n[1] - s_upd[1]);
    end
    n_vec++;
    if (b_upd_n[0] - s_bupd[0] !== 1 || b_upd_n[1] - s_bupd[1] !== 0) begin
      n_err++; $display("FAIL upd_cnt_b got=%0d/%0d exp=1/0", b_upd_n[0] - s_bupd[0], b_upd_n[1] - s_bupd[1]);
    end
    la = int'(a_upd_cyc) - int'(fc);
    lb = int'(b_upd_cyc) - int'(rc);
    n_vec++;
    if (la < S + 1 || la > S + 2) begin n_err++; $display("FAIL upd_lat_fall got=%0d exp=%0d..%0d", la, S + 1, S + 2); end
    n_vec++;
    if (lb < S + 1 || lb > S + 2) begin n_err++; $display("FAIL upd_lat_rise got=%0d exp=%0d..%0d", lb, S + 1, S + 2); end
    n_vec++;
    if (a_cnt !== 8'd3) begin n_err++; $display("FAIL upd_cnt_hold got=%0d exp=3", a_cnt); end
  endtask

  task automatic test_sel_err();
    int d;
    ch_sel_i = 2'b11;
    snap();
    tck_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    idle(4);
    d = 0;
    for (int i = 0; i < N_CH; i++)
      d += (a_cap_n[i] - s_cap[i]) + (a_shf_n[i] - s_shf[i]) + (a_upd_n[i] - s_upd[i]) + (b_upd_n[i] - s_bupd[i]);
    n_vec++;
    if (a_serr !== 1'b1 || b_serr !== 1'b1) begin n_err++; $display("FAIL selerr_set got=%b%b exp=11", a_serr, b_serr); end
    n_vec++;
    if (a_sel !== 2'b00) begin n_err++; $display("FAIL selerr_sel got=%b exp=00", a_sel); end
    n_vec++;
    if (d !== 0) begin n_err++; $display("FAIL selerr_strobes got=%0d exp=0", d); end
    pulse_clr();
    n_vec++;
    if (a_serr !== 1'b0) begin n_err++; $display("FAIL selerr_clr got=%b exp=0", a_serr); end
    ch_sel_i = 2'b01;
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
  endtask

  task automatic test_overrun();
    logic seen;
    ch_sel_i = 2'b10; tdo_i = 2'b10; shift_i = 1'b1;
    snap();
    @(negedge clk);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k < 8 && k % 2 == 0) begin
        tck_divpos_i = ~tck_divpos_i;
        tck_divneg_i = ~tck_divneg_i;
      end
      @(negedge clk);
      seen = seen | a_ovr;
    end
    idle(4);
    n_vec++;
    if (seen !== 1'b1) begin n_err++; $display("FAIL ovr_set got=%b exp=1", seen); end
    n_vec++;
    if (a_shf_n[1] - s_shf[1] !== 4 || a_shf_n[0] - s_shf[0] !== 0) begin
      n_err++; $display("FAIL ovr_strobes got=%0d/%0d exp=4/0", a_shf_n[1] - s_shf[1], a_shf_n[0] - s_shf[0]);
    end
    n_vec++;
    if (a_tdo !== 1'b1 || a_sel !== 2'b10) begin n_err++; $display("FAIL tdo_ch1 got=%b/%b exp=1/10", a_tdo, a_sel); end
    tdo_i = 2'b01;
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    n_vec++;
    if (a_tdo !== 1'b0) begin n_err++; $display("FAIL tdo_ch1_low got=%b exp=0", a_tdo); end
    n_vec++;
    if (a_ovr !== 1'b1) begin n_err++; $display("FAIL ovr_sticky got=%b exp=1", a_ovr); end
    pulse_clr();
    n_vec++;
    if (a_ovr !== 1'b0) begin n_err++; $display("FAIL ovr_clr got=%b exp=0", a_ovr); end
  endtask

  // Random scans against a count/sequence model: capture restarts the count,
  // each shift adds one up to the counter's ceiling.
  task automatic test_random();
    int idx, n, ncap, nshf, ma, mb;
    logic c, s, b;
    for (int it = 0; it < 4; it++) begin
      idx = $urandom_range(0, 1);
      ch_sel_i = (idx == 0) ? 2'b01 : 2'b10;
      tck_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      snap();
      tck_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      ncap = 1; nshf = 0; ma = 0; mb = 0;
      n = $urandom_range(1, 20);
      for (int k = 0; k < n; k++) begin
        c = ($urandom_range(0, 9) == 0);
        s = ($urandom_range(0, 3) != 0);
        b = 1'($urandom_range(0, 1));
        if (c) begin ma = 0; mb = 0; ncap++; end
        else if (s) begin ma = (ma < 255) ? ma + 1 : 255; mb = (mb < 7) ? mb + 1 : 7; end
        if (s) begin nshf++; exp_q.push_back(b); end
        tck_cycle(c, s, 1'b0, b);
      end
      tck_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      idle(4);
      n_vec++;
      if (a_cnt !== 8'(ma) || b_cnt !== 3'(mb)) begin
        n_err++; $display("FAIL rnd%0d_cnt got=%0d/%0d exp=%0d/%0d", it, a_cnt, b_cnt, ma, mb);
      end
      n_vec++;
      if (a_shf_n[idx] - s_shf[idx] !== nshf || a_shf_n[1-idx] - s_shf[1-idx] !== 0) begin
        n_err++; $display("FAIL rnd%0d_shift got=%0d/%0d exp=%0d/0", it, a_shf_n[idx] - s_shf[idx], a_shf_n[1-idx] - s_shf[1-idx], nshf);
      end
      n_vec++;
      if (a_cap_n[idx] - s_cap[idx] !== ncap) begin
        n_err++; $display("FAIL rnd%0d_capture got=%0d exp=%0d", it, a_cap_n[idx] - s_cap[idx], ncap);
      end
      for (int k = 0; k < exp_q.size(); k++) begin
        n_vec++;
        if (tdi_hist[s_tdi + k] !== exp_q[k][0]) begin
          n_err++; $display("FAIL rnd%0d_tdi[%0d] got=%b exp=%b", it, k, tdi_hist[s_tdi + k], exp_q[k][0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int d;
    ch_sel_i = 2'b01;
    tck_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tck_cycle(1'b0, 1'b1, 1'b0, 1'b1);
    shift_i = 1'b1;
    rst = 1'b1;
    tck_divpos_i = 1'b1; tck_divneg_i = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (a_cnt !== 8'd0 || a_sel !== 2'b00 || a_shf !== 2'b00) begin
      n_err++; $display("FAIL mid_rst got=%0d/%b/%b exp=0/00/00", a_cnt, a_sel, a_shf);
    end
    snap();
    repeat (8) @(negedge clk);
    d = 0;
    for (int i = 0; i < N_CH; i++) d += (a_shf_n[i] - s_shf[i]) + (a_cap_n[i] - s_cap[i]);
    n_vec++;
    if (d !== 0) begin n_err++; $display("FAIL mid_rst_mask got=%0d exp=0", d); end
    tck_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    tck_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    tck_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    n_vec++;
    if (a_cnt !== 8'd2) begin n_err++; $display("FAIL mid_rst_resume got=%0d exp=2", a_cnt); end
  endtask

  initial begin
    test_reset();
    test_capture_shift();
    test_saturate();
    test_update();
    test_sel_err();
    test_overrun();
    test_random();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
